// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU counter bank: register indices, CFG bit
// positions and the stored configuration record.
package pmu_pkg;

    localparam int REG_CFG      = 0;
    localparam int REG_MASK     = 1;
    localparam int REG_OVF      = 2;
    localparam int REG_CNT_BASE = 3;

    localparam int CFG_EN      = 0;
    localparam int CFG_CLR     = 1;
    localparam int CFG_SNAP    = 2;
    localparam int CFG_SAT     = 3;
    localparam int CFG_RD_SNAP = 4;
    localparam int CFG_IRQ_EN  = 5;
    localparam int CFG_WIDTH   = 6;

    typedef struct packed {
        logic irq_en;
        logic rd_snap;
        logic sat;
        logic snap;
        logic clr;
        logic en;
    } cfg_t;

    // CLR and SNAP are one-shot commands, so they are never retained.
    function automatic cfg_t cfg_from_wdata(input logic [CFG_WIDTH-1:0] w);
        cfg_t c;
        c.en      = w[CFG_EN];
        c.clr     = 1'b0 & w[CFG_CLR];
        c.snap    = 1'b0 & w[CFG_SNAP];
        c.sat     = w[CFG_SAT];
        c.rd_snap = w[CFG_RD_SNAP];
        c.irq_en  = w[CFG_IRQ_EN];
        return c;
    endfunction

endpackage

// File: rtl/pmu_counter.sv
// One event counter: clear beats software write beats increment; the
// increment either wraps or saturates at all ones and flags the overflow.
module pmu_counter #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inc,
    input  logic             sat,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    logic [WIDTH-1:0] r_value;

    assign value = r_value;
    assign ovf   = inc & ~clr & ~wr_en & (&r_value);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (wr_en) begin
            r_value <= wr_data;
        end else if (inc) begin
            if (&r_value) begin
                r_value <= sat ? r_value : '0;
            end else begin
                r_value <= r_value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmu_counter_bank.sv
// PMU counter core: per-tile event counters with mask, snapshot, sticky
// overflow and interrupt, behind a single valid/ready register port.
module pmu_counter_bank
    import pmu_pkg::*;
#(
    parameter int TILE_COUNT       = 4,
    parameter int EVENT_COUNT      = 23,
    parameter int CNT_WIDTH        = 48,
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_REG_WIDTH   = 6,
    parameter int ADDR_TILE_WIDTH  = 7,
    parameter int ADDR_ALIGN_WIDTH = 3
) (
    input  logic                                                  counter_clk,
    input  logic                                                  rst,
    input  logic [TILE_COUNT-1:0][EVENT_COUNT-1:0]                pmu_sig_i,
    input  logic                                                  req_valid_i,
    output logic                                                  req_ready_o,
    input  logic                                                  req_write_i,
    input  logic [ADDR_TILE_WIDTH+ADDR_REG_WIDTH+ADDR_ALIGN_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]                                 req_wdata_i,
    output logic                                                  rsp_valid_o,
    input  logic                                                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                                 rsp_data_o,
    output logic                                                  rsp_error_o,
    output logic [TILE_COUNT-1:0]                                 irq_o
);

    localparam int REG_COUNT = REG_CNT_BASE + EVENT_COUNT;

    logic [ADDR_REG_WIDTH-1:0]  w_reg;
    logic [ADDR_TILE_WIDTH-1:0] w_tile;
    logic                       w_in_range;
    logic                       w_accept;
    logic                       w_wr;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic                       w_unused;

    logic [CNT_WIDTH-1:0]   w_cnt  [TILE_COUNT][EVENT_COUNT];
    logic [CNT_WIDTH-1:0]   w_snap [TILE_COUNT][EVENT_COUNT];
    cfg_t                   w_cfg  [TILE_COUNT];
    logic [EVENT_COUNT-1:0] w_mask [TILE_COUNT];
    logic [EVENT_COUNT-1:0] w_ovf  [TILE_COUNT];

    logic                  r_rsp_valid;
    logic                  r_rsp_error;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    assign w_reg      = req_addr_i[ADDR_ALIGN_WIDTH +: ADDR_REG_WIDTH];
    assign w_tile     = req_addr_i[ADDR_ALIGN_WIDTH+ADDR_REG_WIDTH +: ADDR_TILE_WIDTH];
    assign w_in_range = (int'(w_tile) < TILE_COUNT) && (int'(w_reg) < REG_COUNT);
    assign w_unused   = ^{req_addr_i[ADDR_ALIGN_WIDTH-1:0], req_wdata_i};

    assign req_ready_o = ~r_rsp_valid | rsp_ready_i;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_wr        = w_accept & req_write_i & w_in_range;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_error_o = r_rsp_error;
    assign rsp_data_o  = r_rsp_data;

    for (genvar t = 0; t < TILE_COUNT; t++) begin : g_tile
        logic                   w_tile_hit;
        logic                   w_clr;
        logic                   w_snap_cmd;
        logic [EVENT_COUNT-1:0] w_ovf_set;
        logic [EVENT_COUNT-1:0] w_ovf_clr;
        cfg_t                   r_cfg;
        logic [EVENT_COUNT-1:0] r_mask;
        logic [EVENT_COUNT-1:0] r_ovf;
        logic                   r_irq;

        assign w_tile_hit = w_wr && (int'(w_tile) == t);
        assign w_clr      = w_tile_hit && (int'(w_reg) == REG_CFG) && req_wdata_i[CFG_CLR];
        assign w_snap_cmd = w_tile_hit && (int'(w_reg) == REG_CFG) && req_wdata_i[CFG_SNAP];
        assign w_ovf_clr  = (w_tile_hit && (int'(w_reg) == REG_OVF)) ?
                            req_wdata_i[EVENT_COUNT-1:0] : '0;

        for (genvar e = 0; e < EVENT_COUNT; e++) begin : g_evt
            logic [CNT_WIDTH-1:0] r_snap;

            pmu_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
                .clk     (counter_clk),
                .rst     (rst),
                .clr     (w_clr),
                .wr_en   (w_tile_hit && (int'(w_reg) == REG_CNT_BASE + e)),
                .wr_data (req_wdata_i[CNT_WIDTH-1:0]),
                .inc     (r_cfg.en & r_mask[e] & pmu_sig_i[t][e]),
                .sat     (r_cfg.sat),
                .value   (w_cnt[t][e]),
                .ovf     (w_ovf_set[e])
            );

            // Snapshot captures the pre-edge value, so it sees neither this
            // cycle's increment nor a simultaneous CLR.
            always_ff @(posedge counter_clk or negedge rst) begin
                if (!rst) begin
                    r_snap <= '0;
                end else if (w_snap_cmd) begin
                    r_snap <= w_cnt[t][e];
                end
            end

            assign w_snap[t][e] = r_snap;
        end

        // A freshly detected overflow outranks a same-cycle W1C.
        always_ff @(posedge counter_clk or negedge rst) begin
            if (!rst) begin
                r_cfg  <= '0;
                r_mask <= '1;
                r_ovf  <= '0;
                r_irq  <= 1'b0;
            end else begin
                r_irq <= r_cfg.irq_en & (|r_ovf);
                r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
                if (w_tile_hit && (int'(w_reg) == REG_CFG)) begin
                    r_cfg <= cfg_from_wdata(req_wdata_i[CFG_WIDTH-1:0]);
                end
                if (w_tile_hit && (int'(w_reg) == REG_MASK)) begin
                    r_mask <= req_wdata_i[EVENT_COUNT-1:0];
                end
            end
        end

        assign w_cfg[t]  = r_cfg;
        assign w_mask[t] = r_mask;
        assign w_ovf[t]  = r_ovf;
        assign irq_o[t]  = r_irq;
    end

    always_comb begin
        w_rd_data = '0;
        for (int t = 0; t < TILE_COUNT; t++) begin
            if (int'(w_tile) == t) begin
                if (int'(w_reg) == REG_CFG) begin
                    w_rd_data = DATA_WIDTH'(w_cfg[t]);
                end else if (int'(w_reg) == REG_MASK) begin
                    w_rd_data = DATA_WIDTH'(w_mask[t]);
                end else if (int'(w_reg) == REG_OVF) begin
                    w_rd_data = DATA_WIDTH'(w_ovf[t]);
                end
                for (int e = 0; e < EVENT_COUNT; e++) begin
                    if (int'(w_reg) == REG_CNT_BASE + e) begin
                        w_rd_data = DATA_WIDTH'(w_cfg[t].rd_snap ? w_snap[t][e] : w_cnt[t][e]);
                    end
                end
            end
        end
    end

    always_ff @(posedge counter_clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_error <= ~w_in_range;
            r_rsp_data  <= !w_in_range ? '1 : (req_write_i ? '0 : w_rd_data);
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Directed bench for pmu_counter_bank (8-bit counters) with a cycle-level
// reference model of the register map checked on every clock.
module tb_pmu_counter_bank;

    localparam int TILES   = 4;
    localparam int EVENTS  = 23;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int NREGS   = 3 + EVENTS;

    logic                           counter_clk;
    logic                           rst;
    logic [TILES-1:0][EVENTS-1:0]   pmu_sig_i;
    logic                           req_valid_i;
    logic                           req_ready_o;
    logic                           req_write_i;
    logic [15:0]                    req_addr_i;
    logic [63:0]                    req_wdata_i;
    logic                           rsp_valid_o;
    logic                           rsp_ready_i;
    logic [63:0]                    rsp_data_o;
    logic                           rsp_error_o;
    logic [TILES-1:0]               irq_o;

    int tests    = 0;
    int failures = 0;

    logic [63:0] rdData;
    logic        rdErr;

    int          mCnt  [TILES][EVENTS];
    int          mSnap [TILES][EVENTS];
    logic [5:0]  mCfg  [TILES];
    logic [22:0] mMask [TILES];
    logic [22:0] mOvf  [TILES];
    logic [3:0]  mIrq;
    logic        mRspValid;
    logic        mRspErr;
    logic [63:0] mRspData;

    pmu_counter_bank #(
        .TILE_COUNT(TILES), .EVENT_COUNT(EVENTS), .CNT_WIDTH(CW), .DATA_WIDTH(64),
        .ADDR_REG_WIDTH(6), .ADDR_TILE_WIDTH(7), .ADDR_ALIGN_WIDTH(3)
    ) dut (
        .counter_clk (counter_clk),
        .rst         (rst),
        .pmu_sig_i   (pmu_sig_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_error_o (rsp_error_o),
        .irq_o       (irq_o)
    );

    initial counter_clk = 1'b0;
    always #5 counter_clk = ~counter_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] addrOf(input int tile, input int r);
        return 16'((tile << 9) | (r << 3));
    endfunction

    function automatic logic [63:0] modelRead(input int tile, input int r);
        if (r == 0) return 64'(mCfg[tile]);
        if (r == 1) return 64'(mMask[tile]);
        if (r == 2) return 64'(mOvf[tile]);
        if (mCfg[tile][4]) return 64'(mSnap[tile][r-3]);
        return 64'(mCnt[tile][r-3]);
    endfunction

    task automatic resetModel();
        for (int t = 0; t < TILES; t++) begin
            for (int e = 0; e < EVENTS; e++) begin
                mCnt[t][e]  = 0;
                mSnap[t][e] = 0;
            end
            mCfg[t]  = '0;
            mMask[t] = '1;
            mOvf[t]  = '0;
        end
        mIrq      = '0;
        mRspValid = 1'b0;
        mRspErr   = 1'b0;
        mRspData  = '0;
    endtask

    // One clock of the register-map rules, using the inputs seen at the edge.
    task automatic modelStep();
        logic        accept, inRange, doWrite, inc, clr, snp, wr;
        int          tile, r, oldV, newV;
        logic [63:0] rspData;
        logic [3:0]  newIrq;
        logic [22:0] setBits, clrBits;
        accept  = req_valid_i && (!mRspValid || rsp_ready_i);
        tile    = int'(req_addr_i[15:9]);
        r       = int'(req_addr_i[8:3]);
        inRange = (tile < TILES) && (r < NREGS);
        doWrite = accept && req_write_i && inRange;
        rspData = !inRange ? '1 : (req_write_i ? 64'd0 : modelRead(tile, r));
        for (int t = 0; t < TILES; t++) newIrq[t] = mCfg[t][5] && (mOvf[t] != 0);
        for (int t = 0; t < TILES; t++) begin
            clr     = doWrite && tile == t && r == 0 && req_wdata_i[1];
            snp     = doWrite && tile == t && r == 0 && req_wdata_i[2];
            setBits = '0;
            for (int e = 0; e < EVENTS; e++) begin
                oldV = mCnt[t][e];
                inc  = mCfg[t][0] && mMask[t][e] && pmu_sig_i[t][e];
                wr   = doWrite && tile == t && r == 3 + e;
                if (snp) mSnap[t][e] = oldV;
                if (clr) newV = 0;
                else if (wr) newV = int'(req_wdata_i % 64'(CNT_MAX + 1));
                else if (inc) begin
                    if (oldV == CNT_MAX) begin
                        setBits[e] = 1'b1;
                        newV = mCfg[t][3] ? CNT_MAX : 0;
                    end else begin
                        newV = oldV + 1;
                    end
                end else newV = oldV;
                mCnt[t][e] = newV;
            end
            clrBits = (doWrite && tile == t && r == 2) ? req_wdata_i[22:0] : '0;
            mOvf[t] = (mOvf[t] & ~clrBits) | setBits;
            if (doWrite && tile == t && r == 0) mCfg[t] = {req_wdata_i[5:3], 2'b00, req_wdata_i[0]};
            if (doWrite && tile == t && r == 1) mMask[t] = req_wdata_i[22:0];
        end
        mIrq = newIrq;
        if (accept) begin
            mRspValid = 1'b1;
            mRspErr   = !inRange;
            mRspData  = rspData;
        end else if (rsp_ready_i) begin
            mRspValid = 1'b0;
        end
    endtask

    always @(posedge counter_clk or negedge rst) begin
        if (!rst) begin
            resetModel();
        end else begin
            modelStep();
            #1;
            checkOutput("cmpReady", 64'(req_ready_o), 64'(!mRspValid || rsp_ready_i));
            checkOutput("cmpRspValid", 64'(rsp_valid_o), 64'(mRspValid));
            checkOutput("cmpIrq", 64'(irq_o), 64'(mIrq));
            if (mRspValid) begin
                checkOutput("cmpRspData", rsp_data_o, mRspData);
                checkOutput("cmpRspErr", 64'(rsp_error_o), 64'(mRspErr));
            end
        end
    end

    task automatic applyStimulus(input logic wr, input int tile, input int r, input logic [63:0] wdata);
        int waitCycles = 0;
        @(negedge counter_clk);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addrOf(tile, r);
        req_wdata_i = wdata;
        while (!req_ready_o && waitCycles < 20) begin
            @(negedge counter_clk);
            waitCycles++;
        end
        if (!req_ready_o) begin
            checkOutput("reqTimeout", 64'(req_ready_o), 64'd1);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge counter_clk);
        #1;
        checkOutput("rspLatency", 64'(rsp_valid_o), 64'd1);
        rdData = rsp_data_o;
        rdErr  = rsp_error_o;
        @(negedge counter_clk);
        req_valid_i = 1'b0;
    endtask

    task automatic pulseEvent(input int tile, input int ev, input int n);
        @(negedge counter_clk);
        pmu_sig_i[tile][ev] = 1'b1;
        repeat (n) @(negedge counter_clk);
        pmu_sig_i[tile][ev] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        pmu_sig_i   = '0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(negedge counter_clk);
        rst = 1'b1;
        @(negedge counter_clk);
        checkOutput("rstIrq", 64'(irq_o), 64'd0);
        checkOutput("rstRspValid", 64'(rsp_valid_o), 64'd0);
        checkOutput("rstReady", 64'(req_ready_o), 64'd1);

        applyStimulus(0, 0, 1, 0);  checkOutput("rstMask", rdData, 64'h7FFFFF);
        applyStimulus(0, 0, 0, 0);  checkOutput("rstCfg", rdData, 64'h0);

        applyStimulus(1, 0, 0, 64'h1);
        pulseEvent(0, 5, 10);
        applyStimulus(0, 0, 8, 0);  checkOutput("count10", rdData, 64'd10);
        applyStimulus(1, 0, 1, 64'h7FFFDF);
        pulseEvent(0, 5, 10);
        applyStimulus(0, 0, 8, 0);  checkOutput("maskedHold", rdData, 64'd10);
        applyStimulus(1, 0, 1, 64'h7FFFFF);

        applyStimulus(1, 1, 0, 64'h1);
        applyStimulus(1, 1, 3, 64'hFE);
        pulseEvent(1, 0, 3);
        applyStimulus(0, 1, 3, 0);  checkOutput("wrapValue", rdData, 64'h01);
        applyStimulus(0, 1, 2, 0);  checkOutput("wrapOvf", rdData, 64'h1);
        applyStimulus(1, 1, 0, 64'h9);
        applyStimulus(1, 1, 3, 64'h1FE);
        pulseEvent(1, 0, 3);
        applyStimulus(0, 1, 3, 0);  checkOutput("satValue", rdData, 64'hFF);
        applyStimulus(1, 1, 2, 64'h1);
        applyStimulus(0, 1, 2, 0);  checkOutput("ovfW1c", rdData, 64'h0);

        applyStimulus(1, 1, 0, 64'h21);
        applyStimulus(1, 1, 3, 64'hFF);
        pulseEvent(1, 0, 1);
        checkOutput("irqNotYet", 64'(irq_o[1]), 64'd0);
        @(posedge counter_clk); #1;
        checkOutput("irqRaised", 64'(irq_o[1]), 64'd1);
        applyStimulus(1, 1, 2, 64'h1);
        @(posedge counter_clk); #1;
        checkOutput("irqDropped", 64'(irq_o[1]), 64'd0);

        applyStimulus(1, 2, 0, 64'h1);
        applyStimulus(1, 2, 3, 64'd100);
        applyStimulus(1, 2, 0, 64'h17);
        applyStimulus(0, 2, 3, 0);  checkOutput("snapRead", rdData, 64'd100);
        pulseEvent(2, 0, 5);
        applyStimulus(0, 2, 3, 0);  checkOutput("snapHeld", rdData, 64'd100);
        applyStimulus(0, 2, 0, 0);  checkOutput("cfgSelfClr", rdData, 64'h11);
        applyStimulus(1, 2, 0, 64'h1);
        applyStimulus(0, 2, 3, 0);  checkOutput("liveAfterClr", rdData, 64'd5);

        applyStimulus(0, 9, 0, 0);
        checkOutput("badTileErr", 64'(rdErr), 64'd1);
        checkOutput("badTileData", rdData, '1);
        applyStimulus(1, 0, 40, 64'h55);
        checkOutput("badRegErr", 64'(rdErr), 64'd1);
        applyStimulus(0, 0, 8, 0);  checkOutput("badRegNoEffect", rdData, 64'd10);
        applyStimulus(0, 0, 0, 0);  checkOutput("cfgUnchanged", rdData, 64'h1);

        @(negedge counter_clk);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = addrOf(0, 8);
        @(posedge counter_clk); #1;
        checkOutput("stallRspValid", 64'(rsp_valid_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge counter_clk);
            checkOutput("stallReady", 64'(req_ready_o), 64'd0);
            checkOutput("stallData", rsp_data_o, 64'd10);
        end
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncRstValid", 64'(rsp_valid_o), 64'd0);
        checkOutput("asyncRstData", rsp_data_o, 64'd0);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge counter_clk);
        rst = 1'b1;
        applyStimulus(0, 0, 8, 0);  checkOutput("cntAfterRst", rdData, 64'd0);
        repeat (2) @(negedge counter_clk);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
